config_sequencer: RTL and testbench
===================================

# config_sequencer

Streams configuration words from a host interface onto the fabric's shared `config_addr`/`config_data` bus, one write per slot, with a programmable idle gap between writes so switch boxes, connect boxes and CLBs latch cleanly. Buffers host words in a small FIFO, filters addresses whose feature ID (`addr[31:16]`) is not a legal tile feature, and holds the fabric out of run mode while a bitstream is being loaded. Sits between the host/bitstream source and the top of the tile array; every tile decodes the bus it drives.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: input FIFO entries, power of two, ≥2.
- `GAP_CYCLES`, 1: idle-address cycles after each driven write, 0..15.
- `MIN_FEATURE`, 4: lowest legal feature ID (CLB).
- `MAX_FEATURE`, 7: highest legal feature ID (switch box).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  host word valid.
- `in_ready`  out  1  FIFO can accept a word.
- `in_addr`  in  32  `[31:16]` feature ID, `[15:0]` tile ID.
- `in_data`  in  32  configuration payload.
- `in_last`  in  1  final word of a bitstream.
- `config_addr`  out  32  fabric config address bus, registered.
- `config_data`  out  32  fabric config data bus, registered.
- `fabric_run`  out  1  high when no bitstream is loading.
- `config_done`  out  1  one-cycle pulse at end of a bitstream.
- `config_err`  out  1  sticky; a word with an illegal feature ID was dropped.
- `word_count`  out  16  words driven in current/last bitstream, saturating.

## Operation
- Handshake: a word is pushed when `in_valid && in_ready`. `in_ready = !fifo_full`; there is no bypass, so a full FIFO never accepts a word even if a pop occurs in the same cycle.
- Idle address is `32'h0000_0000`. Feature 0 decodes to no tile feature. `config_addr` and `config_data` are both 0 in every cycle that is not a DRIVE cycle.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop and go to DRIVE.
  - DRIVE: drives exactly one cycle. If the popped feature ID is within [MIN_FEATURE, MAX_FEATURE], put addr/data on the bus and increment `word_count`. Otherwise put the idle address on the bus and set `config_err`. Then go to GAP, or to IDLE/DONE directly if GAP_CYCLES=0.
  - GAP: idle address for GAP_CYCLES cycles, counted by a 4-bit down-counter. Then go to DONE if the driven word carried `in_last`, else to IDLE.
  - DONE: pulse `config_done`, set `fabric_run`, then go to IDLE.
- Start of a bitstream is the first pop while `fabric_run=1`, or the first pop after reset. On that pop:
  - `fabric_run` drops in the same edge.
  - `word_count` clears to 0, then counts that word if it is legal.
- A dropped (illegal) word still consumes a full DRIVE+GAP slot and still honours `in_last`.
- `word_count` saturates at 16'hFFFF.
- `config_err` clears only on reset.

## Timing
- Reset (asynchronous assert) sets: FIFO empty, state IDLE, `config_addr=0`, `config_data=0`, `fabric_run=0`, `config_done=0`, `config_err=0`, `word_count=0`. `in_ready=1` once reset deasserts.
- Reset mid-bitstream aborts it. Any partially written tile state stays in the fabric, and `fabric_run` stays 0 until a complete bitstream finishes.
- Latency: a word accepted at edge E into an empty FIFO with the FSM in IDLE is popped at E+1. It is on the bus from E+1 to E+2.
- Throughput: one write per 1+GAP_CYCLES cycles.
- `config_done` and `fabric_run` rise at the edge after the last GAP cycle, or after the last DRIVE cycle if GAP_CYCLES=0.
- Simultaneous push and pop on a non-full FIFO is allowed; occupancy is unchanged.

## Structure
- Shared package `config_pkg`:
  - `FEATURE_CLB=4`, `FEATURE_CB1=5`, `FEATURE_CB0=6`, `FEATURE_SB=7`.
  - `CONFIG_IDLE_ADDR=32'h0`.
  - FSM state enum.
- Sub-module `config_fifo`:
  - Synchronous FIFO, 65-bit entry {last, addr, data}, depth FIFO_DEPTH.
  - Ports: push, pop, full, empty.
  - Same clock and async active-low reset.
- FSM, gap counter and output registers live in `config_sequencer`.

## Test plan
- Reset, then push one word {addr 32'h0007_0003, data 32'h5, last=1} with GAP=1 → bus shows 0007_0003/5 for exactly one cycle, 0 next cycle, then `config_done` pulse; `fabric_run`=1 and `word_count`=1.
- Push 6 words back-to-back with `in_valid` held high, DEPTH=4 → `in_ready` drops when the FIFO is full, no word is lost, and words are driven in order every 2 cycles.
- Word with feature 2 (addr 32'h0002_0001) mid-stream → bus stays 0 in its slot, `config_err`=1 sticky, `word_count` excludes it.
- GAP_CYCLES=0, 3 words with last on the third → writes on consecutive cycles, `config_done` the cycle after the third.
- Assert reset during the GAP of word 2 of 4 → all outputs 0 immediately and `fabric_run`=0. A new 1-word bitstream then completes normally with `word_count`=1.
- Second bitstream after the first completes → `fabric_run` drops on its first pop and `word_count` restarts from 0.

Source files
------------

// File: rtl/config_pkg.sv
// Shared constants for the fabric configuration path: tile feature IDs, idle bus address, sequencer states.
package config_pkg;

    localparam int FEATURE_CLB = 4;
    localparam int FEATURE_CB1 = 5;
    localparam int FEATURE_CB0 = 6;
    localparam int FEATURE_SB  = 7;

    localparam logic [31:0] CONFIG_IDLE_ADDR = 32'h0000_0000;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DRIVE = 2'd1;
    localparam state_t ST_GAP   = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic logic feature_legal(input logic [15:0] feature,
                                           input logic [15:0] lo,
                                           input logic [15:0] hi);
        return (feature >= lo) && (feature <= hi);
    endfunction

endpackage

// File: rtl/config_fifo.sv
// Purpose: synchronous FIFO holding {last, addr, data} host words.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: full blocks push; no bypass, so a full FIFO ignores push even on a pop cycle.
module config_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/config_sequencer.sv
// Purpose: drains buffered host config words onto the fabric config bus, one filtered write per slot.
// Latency: word accepted at edge E into an empty FIFO is on the bus from E+1 to E+2.
// Backpressure: in_ready = !fifo_full; one pop per 1+GAP_CYCLES cycles drains the FIFO.
module config_sequencer
    import config_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int MIN_FEATURE = FEATURE_CLB,
    parameter int MAX_FEATURE = FEATURE_SB
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        fabric_run,
    output logic        config_done,
    output logic        config_err,
    output logic [15:0] word_count
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [64:0] fifo_dout;

    state_t      state;
    logic [3:0]  gap_cnt;
    logic        last_q;
    logic        start_pending;
    logic        slot_end;
    logic        head_legal;
    logic        bs_start;

    config_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (65)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (fifo_pop),
        .din   ({in_last, in_addr, in_data}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    assign in_ready    = !fifo_full;
    assign config_done = (state == ST_DONE);

    // The final cycle of a slot pops the next word directly so writes stay 1+GAP_CYCLES apart.
    assign slot_end   = ((state == ST_DRIVE) && (GAP_CYCLES == 0)) ||
                        ((state == ST_GAP) && (gap_cnt == 4'd0));
    assign fifo_pop   = !fifo_empty && ((state == ST_IDLE) || (slot_end && !last_q));
    assign head_legal = feature_legal(fifo_dout[63:48], 16'(MIN_FEATURE), 16'(MAX_FEATURE));
    assign bs_start   = fifo_pop && start_pending;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            gap_cnt       <= '0;
            last_q        <= 1'b0;
            start_pending <= 1'b1;
            config_addr   <= CONFIG_IDLE_ADDR;
            config_data   <= '0;
            fabric_run    <= 1'b0;
            config_err    <= 1'b0;
            word_count    <= '0;
        end else begin
            config_addr <= CONFIG_IDLE_ADDR;
            config_data <= '0;

            case (state)
                ST_DRIVE: begin
                    if (GAP_CYCLES != 0) begin
                        state   <= ST_GAP;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
                end
                default: state <= ST_IDLE;
            endcase

            if (slot_end) begin
                if (last_q) begin
                    state         <= ST_DONE;
                    fabric_run    <= 1'b1;
                    start_pending <= 1'b1;
                end else begin
                    state <= ST_IDLE;
                end
            end

            // Dropped words still take a full slot and still honour last.
            if (fifo_pop) begin
                state  <= ST_DRIVE;
                last_q <= fifo_dout[64];
                if (head_legal) begin
                    config_addr <= fifo_dout[63:32];
                    config_data <= fifo_dout[31:0];
                end else begin
                    config_err <= 1'b1;
                end
                if (bs_start) begin
                    fabric_run    <= 1'b0;
                    start_pending <= 1'b0;
                    word_count    <= head_legal ? 16'd1 : 16'd0;
                end else if (head_legal && (word_count != 16'hFFFF)) begin
                    word_count <= word_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_config_sequencer.sv
// Directed bench for config_sequencer: one GAP_CYCLES=1 instance and one GAP_CYCLES=0 instance.
module tb_config_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_last;
    logic [31:0] in_addr, in_data, cfg_addr, cfg_data;
    logic        fabric_run, config_done, config_err;
    logic [15:0] word_count;

    logic        in_valid0, in_ready0, in_last0;
    logic [31:0] in_addr0, in_data0, cfg_addr0, cfg_data0;
    logic        fabric_run0, config_done0, config_err0;
    logic [15:0] word_count0;

    config_sequencer #(.FIFO_DEPTH(4), .GAP_CYCLES(1), .MIN_FEATURE(4), .MAX_FEATURE(7)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_data(in_data), .in_last(in_last), .config_addr(cfg_addr), .config_data(cfg_data),
        .fabric_run(fabric_run), .config_done(config_done), .config_err(config_err),
        .word_count(word_count)
    );

    config_sequencer #(.FIFO_DEPTH(4), .GAP_CYCLES(0), .MIN_FEATURE(4), .MAX_FEATURE(7)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0), .in_addr(in_addr0),
        .in_data(in_data0), .in_last(in_last0), .config_addr(cfg_addr0), .config_data(cfg_data0),
        .fabric_run(fabric_run0), .config_done(config_done0), .config_err(config_err0),
        .word_count(word_count0)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit saw_not_ready;

    logic [31:0] w_addr [8];
    logic [31:0] w_data [8];
    logic        w_last [8];

    // Bus write and done-pulse log, sampled on the falling edge.
    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    int          q_cyc  [$];
    logic        q_run  [$];
    logic [15:0] q_wc   [$];
    int          d_cyc  [$];
    logic        d_run  [$];
    logic [31:0] q0_addr [$];
    int          q0_cyc  [$];
    int          d0_cyc  [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cfg_addr != 32'h0 || cfg_data != 32'h0) begin
            q_addr.push_back(cfg_addr);
            q_data.push_back(cfg_data);
            q_cyc.push_back(cyc);
            q_run.push_back(fabric_run);
            q_wc.push_back(word_count);
        end
        if (config_done) begin
            d_cyc.push_back(cyc);
            d_run.push_back(fabric_run);
        end
        if (cfg_addr0 != 32'h0) begin
            q0_addr.push_back(cfg_addr0);
            q0_cyc.push_back(cyc);
        end
        if (config_done0) d0_cyc.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        q_addr.delete(); q_data.delete(); q_cyc.delete(); q_run.delete(); q_wc.delete();
        d_cyc.delete(); d_run.delete(); q0_addr.delete(); q0_cyc.delete(); d0_cyc.delete();
    endtask

    // Holds valid high and walks the word table, advancing only on an accepted handshake.
    task automatic send_words(input int n, input bit use0);
        int   k = 0;
        int   budget = 0;
        logic rdy;
        while (k < n && budget < 100) begin
            if (use0) begin
                in_valid0 = 1'b1; in_addr0 = w_addr[k]; in_data0 = w_data[k]; in_last0 = w_last[k];
                rdy = in_ready0;
            end else begin
                in_valid = 1'b1; in_addr = w_addr[k]; in_data = w_data[k]; in_last = w_last[k];
                rdy = in_ready;
            end
            if (!rdy) saw_not_ready = 1'b1;
            tick();
            if (rdy) k++;
            budget++;
        end
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
        n_cmp++;
        if (k != n) begin n_fail++; $display("FAIL send_words: accepted %0d words, required %0d", k, n); end
    endtask

    task automatic test_reset();
        in_valid = 0; in_addr = 0; in_data = 0; in_last = 0;
        in_valid0 = 0; in_addr0 = 0; in_data0 = 0; in_last0 = 0;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (cfg_addr !== 32'h0 || cfg_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus: got %h/%h required 0/0", cfg_addr, cfg_data);
        end
        n_cmp++;
        if ({fabric_run, config_done, config_err} !== 3'b000 || word_count !== 16'h0) begin
            n_fail++; $display("FAIL reset_status: got run=%b done=%b err=%b wc=%h required all 0",
                               fabric_run, config_done, config_err, word_count);
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || in_ready0 !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b/%b required 1/1", in_ready, in_ready0);
        end
        tick();
    endtask

    task automatic test_single_word();
        in_valid = 1; in_addr = 32'h0007_0003; in_data = 32'h5; in_last = 1;
        tick();
        in_valid = 0;
        n_cmp++;
        if (cfg_addr !== 32'h0) begin n_fail++; $display("FAIL single_early: got %h required 0", cfg_addr); end
        tick();
        n_cmp++;
        if (cfg_addr !== 32'h0007_0003 || cfg_data !== 32'h5) begin
            n_fail++; $display("FAIL single_drive: got %h/%h required 00070003/00000005", cfg_addr, cfg_data);
        end
        tick();
        n_cmp++;
        if (cfg_addr !== 32'h0 || cfg_data !== 32'h0 || config_done !== 1'b0) begin
            n_fail++; $display("FAIL single_gap: got %h/%h done=%b required 0/0 done=0", cfg_addr, cfg_data, config_done);
        end
        tick();
        n_cmp++;
        if (config_done !== 1'b1 || fabric_run !== 1'b1 || word_count !== 16'd1) begin
            n_fail++; $display("FAIL single_done: got done=%b run=%b wc=%0d required 1 1 1", config_done, fabric_run, word_count);
        end
        tick();
        n_cmp++;
        if (config_done !== 1'b0 || fabric_run !== 1'b1) begin
            n_fail++; $display("FAIL single_pulse: got done=%b run=%b required 0 1", config_done, fabric_run);
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        saw_not_ready = 1'b0;
        w_addr[0] = 32'h0007_00AA; w_data[0] = 32'hAA; w_last[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            w_addr[i] = {16'(4 + (i % 4)), 16'(i)};
            w_data[i] = 32'hB0 + 32'(i);
            w_last[i] = (i == 6);
        end
        send_words(7, 1'b0);
        repeat (14) tick();
        n_cmp++;
        if (saw_not_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_drop: got %b required 1", saw_not_ready); end
        n_cmp++;
        if (q_addr.size() != 7) begin
            n_fail++; $display("FAIL b2b_write_count: got %0d required 7", q_addr.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_cmp++;
                if (q_addr[i] !== w_addr[i] || q_data[i] !== w_data[i]) begin
                    n_fail++; $display("FAIL b2b_order[%0d]: got %h/%h required %h/%h", i, q_addr[i], q_data[i], w_addr[i], w_data[i]);
                end
            end
            for (int i = 2; i < 7; i++) begin
                n_cmp++;
                if (q_cyc[i] - q_cyc[i-1] != 2) begin
                    n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d cycles required 2", i, q_cyc[i] - q_cyc[i-1]);
                end
            end
            n_cmp++;
            if (q_run[1] !== 1'b0 || q_wc[1] !== 16'd1) begin
                n_fail++; $display("FAIL b2b_restart: got run=%b wc=%0d required 0 1", q_run[1], q_wc[1]);
            end
            n_cmp++;
            if (d_cyc.size() != 2 || d_run[0] !== 1'b1 || d_cyc[1] != q_cyc[6] + 2) begin
                n_fail++; $display("FAIL b2b_done: got %0d pulses, required 2 with second 2 cycles after last write", d_cyc.size());
            end
        end
        n_cmp++;
        if (word_count !== 16'd6 || fabric_run !== 1'b1) begin
            n_fail++; $display("FAIL b2b_final: got wc=%0d run=%b required 6 1", word_count, fabric_run);
        end
    endtask

    task automatic test_illegal_word();
        clear_queues();
        n_cmp++;
        if (config_err !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b required 0", config_err); end
        w_addr[0] = 32'h0005_0010; w_data[0] = 32'h11; w_last[0] = 1'b0;
        w_addr[1] = 32'h0002_0001; w_data[1] = 32'h22; w_last[1] = 1'b0;
        w_addr[2] = 32'h0006_0011; w_data[2] = 32'h33; w_last[2] = 1'b1;
        send_words(3, 1'b0);
        repeat (8) tick();
        n_cmp++;
        if (q_addr.size() != 2) begin
            n_fail++; $display("FAIL illegal_write_count: got %0d required 2", q_addr.size());
        end else begin
            n_cmp++;
            if (q_addr[0] !== 32'h0005_0010 || q_addr[1] !== 32'h0006_0011 || q_cyc[1] - q_cyc[0] != 4) begin
                n_fail++; $display("FAIL illegal_slot: got %h@%0d %h@%0d required 00050010, 00060011 4 cycles later",
                                   q_addr[0], q_cyc[0], q_addr[1], q_cyc[1]);
            end
            n_cmp++;
            if (q_wc[0] !== 16'd1 || q_wc[1] !== 16'd2 || q_run[0] !== 1'b0) begin
                n_fail++; $display("FAIL illegal_count: got wc=%0d,%0d run=%b required 1,2 run=0", q_wc[0], q_wc[1], q_run[0]);
            end
            n_cmp++;
            if (d_cyc.size() != 1 || d_cyc[0] != q_cyc[1] + 2) begin
                n_fail++; $display("FAIL illegal_done: got %0d pulses required 1 two cycles after last write", d_cyc.size());
            end
        end
        n_cmp++;
        if (config_err !== 1'b1 || word_count !== 16'd2) begin
            n_fail++; $display("FAIL illegal_err: got err=%b wc=%0d required 1 2", config_err, word_count);
        end
        repeat (5) tick();
        n_cmp++;
        if (config_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b required 1", config_err); end
    endtask

    task automatic test_gap_zero();
        clear_queues();
        w_addr[0] = 32'h0004_0100; w_data[0] = 32'hD1; w_last[0] = 1'b0;
        w_addr[1] = 32'h0007_0200; w_data[1] = 32'hD2; w_last[1] = 1'b0;
        w_addr[2] = 32'h0005_0300; w_data[2] = 32'hD3; w_last[2] = 1'b1;
        send_words(3, 1'b1);
        repeat (6) tick();
        n_cmp++;
        if (q0_addr.size() != 3) begin
            n_fail++; $display("FAIL gap0_write_count: got %0d required 3", q0_addr.size());
        end else begin
            n_cmp++;
            if (q0_addr[0] !== w_addr[0] || q0_addr[1] !== w_addr[1] || q0_addr[2] !== w_addr[2]) begin
                n_fail++; $display("FAIL gap0_order: got %h %h %h", q0_addr[0], q0_addr[1], q0_addr[2]);
            end
            n_cmp++;
            if (q0_cyc[1] - q0_cyc[0] != 1 || q0_cyc[2] - q0_cyc[1] != 1) begin
                n_fail++; $display("FAIL gap0_spacing: got %0d,%0d required 1,1", q0_cyc[1] - q0_cyc[0], q0_cyc[2] - q0_cyc[1]);
            end
            n_cmp++;
            if (d0_cyc.size() != 1 || d0_cyc[0] != q0_cyc[2] + 1) begin
                n_fail++; $display("FAIL gap0_done: got %0d pulses required 1 one cycle after third write", d0_cyc.size());
            end
        end
        n_cmp++;
        if (word_count0 !== 16'd3 || fabric_run0 !== 1'b1) begin
            n_fail++; $display("FAIL gap0_final: got wc=%0d run=%b required 3 1", word_count0, fabric_run0);
        end
    endtask

    task automatic test_reset_midstream();
        clear_queues();
        for (int i = 0; i < 4; i++) begin
            w_addr[i] = {16'(4 + i), 16'(i + 8'h20)};
            w_data[i] = 32'hF0 + 32'(i);
            w_last[i] = (i == 3);
        end
        send_words(4, 1'b0);
        tick();
        n_cmp++;
        if (q_addr.size() != 2) begin n_fail++; $display("FAIL mid_pre_writes: got %0d required 2", q_addr.size()); end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (cfg_addr !== 32'h0 || cfg_data !== 32'h0 || fabric_run !== 1'b0 || config_done !== 1'b0 || word_count !== 16'h0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h/%h run=%b done=%b wc=%0d required all 0",
                               cfg_addr, cfg_data, fabric_run, config_done, word_count);
        end
        #2 reset = 1'b1;
        clear_queues();
        repeat (5) tick();
        n_cmp++;
        if (q_addr.size() != 0 || fabric_run !== 1'b0) begin
            n_fail++; $display("FAIL mid_flushed: got %0d writes run=%b required 0 writes run=0", q_addr.size(), fabric_run);
        end
        w_addr[0] = 32'h0004_0042; w_data[0] = 32'h42; w_last[0] = 1'b1;
        send_words(1, 1'b0);
        repeat (5) tick();
        n_cmp++;
        if (q_addr.size() != 1 || d_cyc.size() != 1) begin
            n_fail++; $display("FAIL mid_new_stream: got %0d writes %0d dones required 1 1", q_addr.size(), d_cyc.size());
        end
        n_cmp++;
        if (word_count !== 16'd1 || fabric_run !== 1'b1 || config_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_new_final: got wc=%0d run=%b err=%b required 1 1 0", word_count, fabric_run, config_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_illegal_word();
        test_gap_zero();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
